// File: rtl/udp_tx_sched.sv
// -----------------------------------------------------------------------------
// udp_tx_sched
//   Frame scheduler for the UDP transmit engine. It watches the read-side fill
//   level of the AD-sample FIFO and decides when to launch a frame and how many
//   payload bytes it carries. A full frame of PKT_BYTES goes out as soon as the
//   level reaches threshold. Residual sub-threshold data is flushed as a
//   partial frame after FLUSH_CYCLES of non-empty waiting. After udp_tx reports
//   tx_done, or the watchdog expires, an inter-frame gap is enforced.
//
// Ports
//   clk          in   system clock (GMII TX domain)
//   rst_n        in   asynchronous reset, active low
//   enable       in   level-sensitive scheduling enable
//   fifo_rd_cnt  in   FIFO read-side fill level in bytes
//   tx_done      in   one-cycle frame-complete pulse from udp_tx
//   tx_start_en  out  frame start request, held START_HOLD cycles
//   tx_byte_num  out  payload byte count of the launched frame
//   busy         out  high while in START, BUSY or GAP
//   frame_cnt    out  frames completed with tx_done (wrapping)
//   timeout_err  out  one-cycle pulse when the tx_done watchdog expires
// -----------------------------------------------------------------------------
module udp_tx_sched #(
    parameter int unsigned PKT_BYTES    = 1024,
    parameter int unsigned LVL_W        = 11,
    parameter int unsigned START_HOLD   = 4,
    parameter int unsigned IFG_CYCLES   = 16,
    parameter int unsigned FLUSH_CYCLES = 125000,
    parameter int unsigned DONE_TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [LVL_W-1:0] fifo_rd_cnt,
    input  logic             tx_done,
    output logic             tx_start_en,
    output logic [15:0]      tx_byte_num,
    output logic             busy,
    output logic [15:0]      frame_cnt,
    output logic             timeout_err
);

    localparam int unsigned HoldW  = $clog2(START_HOLD + 1);
    localparam int unsigned GapW   = $clog2(IFG_CYCLES + 1);
    localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned WdW    = $clog2(DONE_TIMEOUT + 1);

    localparam logic [LVL_W-1:0]  PktLvl    = LVL_W'(PKT_BYTES);
    localparam logic [15:0]       PktNum    = 16'(PKT_BYTES);
    localparam logic [HoldW-1:0]  HoldLast  = HoldW'(START_HOLD - 1);
    localparam logic [GapW-1:0]   GapLast   = GapW'(IFG_CYCLES - 1);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_CYCLES - 1);
    localparam logic [WdW-1:0]    WdLast    = WdW'(DONE_TIMEOUT - 1);

    typedef enum logic [4:0] {
        StIdle     = 5'b00001,
        StWaitData = 5'b00010,
        StStart    = 5'b00100,
        StBusy     = 5'b01000,
        StGap      = 5'b10000
    } state_e;

    state_e            state_q;
    logic [HoldW-1:0]  hold_cnt_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic [FlushW-1:0] flush_cnt_q;
    logic [WdW-1:0]    wd_cnt_q;

    // All outputs are registered and updated together with the state so that
    // tx_start_en, busy and tx_byte_num change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            flush_cnt_q <= '0;
            wd_cnt_q    <= '0;
            tx_start_en <= 1'b0;
            tx_byte_num <= '0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q     <= StWaitData;
                        flush_cnt_q <= '0;
                    end
                end

                StWaitData: begin
                    if (!enable) begin
                        state_q <= StIdle;
                    end else if (fifo_rd_cnt >= PktLvl) begin
                        tx_byte_num <= PktNum;
                        state_q     <= StStart;
                        tx_start_en <= 1'b1;
                        busy        <= 1'b1;
                        hold_cnt_q  <= '0;
                    end else if (fifo_rd_cnt == '0) begin
                        // An empty FIFO restarts the flush timeout.
                        flush_cnt_q <= '0;
                    end else if (flush_cnt_q == FlushLast) begin
                        // Non-zero level guarantees no zero-length launch.
                        tx_byte_num <= 16'(fifo_rd_cnt);
                        flush_cnt_q <= '0;
                        state_q     <= StStart;
                        tx_start_en <= 1'b1;
                        busy        <= 1'b1;
                        hold_cnt_q  <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FlushW'(1);
                    end
                end

                StStart: begin
                    if (hold_cnt_q == HoldLast) begin
                        state_q     <= StBusy;
                        tx_start_en <= 1'b0;
                        wd_cnt_q    <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HoldW'(1);
                    end
                end

                StBusy: begin
                    // tx_done wins over a coincident watchdog expiry.
                    if (tx_done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state_q   <= StGap;
                        gap_cnt_q <= '0;
                    end else if (wd_cnt_q == WdLast) begin
                        timeout_err <= 1'b1;
                        state_q     <= StGap;
                        gap_cnt_q   <= '0;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WdW'(1);
                    end
                end

                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        busy <= 1'b0;
                        if (enable) begin
                            state_q     <= StWaitData;
                            flush_cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapW'(1);
                    end
                end

                default: begin
                    state_q     <= StIdle;
                    tx_start_en <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_sched.sv
module tb_udp_tx_sched;

    localparam int unsigned LVL_W = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [LVL_W-1:0] fifo_rd_cnt;
    logic             tx_done;
    logic             tx_start_en;
    logic [15:0]      tx_byte_num;
    logic             busy;
    logic [15:0]      frame_cnt;
    logic             timeout_err;

    int checks   = 0;
    int failures = 0;

    // Short flush and watchdog limits keep the run brief; everything else default.
    udp_tx_sched #(
        .PKT_BYTES    (1024),
        .LVL_W        (LVL_W),
        .START_HOLD   (4),
        .IFG_CYCLES   (16),
        .FLUSH_CYCLES (200),
        .DONE_TIMEOUT (300)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .fifo_rd_cnt (fifo_rd_cnt),
        .tx_done     (tx_done),
        .tx_start_en (tx_start_en),
        .tx_byte_num (tx_byte_num),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        fifo_rd_cnt = '0;
        tx_done     = 1'b0;
        tick(2);
        chk("rst_start", 32'(tx_start_en), 32'd0);
        chk("rst_bytes", 32'(tx_byte_num), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frame_cnt), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Full frame at threshold: start one cycle after the crossing, held 4 cycles.
        enable = 1'b1;
        tick(1);
        fifo_rd_cnt = 11'd1024;
        tick(1);
        chk("full_start", 32'(tx_start_en), 32'd1);
        chk("full_bytes", 32'(tx_byte_num), 32'd1024);
        chk("full_busy", 32'(busy), 32'd1);
        chk("full_frames0", 32'(frame_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("start_hold", 32'(tx_start_en), 32'd1);
        end
        tick(1);
        chk("start_drop", 32'(tx_start_en), 32'd0);
        chk("busy_in_busy", 32'(busy), 32'd1);

        // tx_done completes the frame; 16-cycle gap, then relaunch at full level.
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("done_frames1", 32'(frame_cnt), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            chk("gap_no_start", 32'(tx_start_en), 32'd0);
        end
        chk("gap_exit_busy", 32'(busy), 32'd0);
        tick(1);
        chk("relaunch_start", 32'(tx_start_en), 32'd1);
        chk("relaunch_bytes", 32'(tx_byte_num), 32'd1024);

        // Watchdog: 300 cycles in BUSY without tx_done.
        fifo_rd_cnt = '0;
        tick(4);
        tick(299);
        chk("tmo_early", 32'(timeout_err), 32'd0);
        tick(1);
        chk("tmo_pulse", 32'(timeout_err), 32'd1);
        chk("tmo_frames", 32'(frame_cnt), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd1);
        tick(1);
        chk("tmo_single", 32'(timeout_err), 32'd0);
        tick(15);
        chk("tmo_gap_exit", 32'(busy), 32'd0);
        fifo_rd_cnt = 11'd1024;
        tick(1);
        chk("tmo_then_wait", 32'(tx_start_en), 32'd1);

        // enable drop during BUSY: frame completes, then IDLE with no new starts.
        tick(4);
        enable = 1'b0;
        tick(5);
        chk("dis_still_busy", 32'(busy), 32'd1);
        chk("dis_no_start", 32'(tx_start_en), 32'd0);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("dis_frames2", 32'(frame_cnt), 32'd2);
        tick(16);
        chk("dis_idle_busy", 32'(busy), 32'd0);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("stray_done", 32'(frame_cnt), 32'd2);
        tick(20);
        chk("idle_no_start", 32'(tx_start_en), 32'd0);
        chk("idle_no_busy", 32'(busy), 32'd0);

        // Partial flush: 200 non-empty cycles; an empty cycle restarts the count.
        enable      = 1'b1;
        fifo_rd_cnt = '0;
        tick(1);
        fifo_rd_cnt = 11'd300;
        tick(100);
        chk("flush_pre_drop", 32'(tx_start_en), 32'd0);
        fifo_rd_cnt = '0;
        tick(1);
        fifo_rd_cnt = 11'd300;
        tick(199);
        chk("flush_early", 32'(tx_start_en), 32'd0);
        tick(1);
        chk("flush_start", 32'(tx_start_en), 32'd1);
        chk("flush_bytes", 32'(tx_byte_num), 32'd300);
        chk("flush_busy", 32'(busy), 32'd1);

        // Asynchronous reset in the middle of BUSY.
        tick(4);
        fifo_rd_cnt = 11'd500;
        tick(2);
        chk("bytes_held", 32'(tx_byte_num), 32'd300);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_start", 32'(tx_start_en), 32'd0);
        chk("arst_bytes", 32'(tx_byte_num), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_frames", 32'(frame_cnt), 32'd0);
        chk("arst_tmo", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        fifo_rd_cnt = 11'd1024;
        tick(1);
        chk("post_rst_idle", 32'(tx_start_en), 32'd0);
        tick(1);
        chk("post_rst_start", 32'(tx_start_en), 32'd1);
        chk("post_rst_bytes", 32'(tx_byte_num), 32'd1024);

        // tx_done coinciding with watchdog expiry counts as success.
        tick(4);
        fifo_rd_cnt = '0;
        tick(299);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("tie_frames", 32'(frame_cnt), 32'd1);
        chk("tie_no_tmo", 32'(timeout_err), 32'd0);
        tick(1);
        chk("tie_no_tmo_late", 32'(timeout_err), 32'd0);
        chk("tie_busy_gap", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
